// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared pixel definitions for the HDMI video path: pixel
//               width, RGB pixel struct and the legacy pipe delay.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    // 8b R, 8b G, 8b B
    localparam int PIXEL_W = 24;

    // Delay loaded at reset; matches the timing of the old fixed 4-stage pipe
    localparam int DEFAULT_DELAY = 4;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage
`default_nettype wire

// File: rtl/delay_stage.sv
`default_nettype none
// ============================================================================
// Module      : delay_stage
// Description : One {valid, data} register of the pixel delay line. Data and
//               valid advance only when enabled; the valid bit can be cleared
//               independently of the enable so a delay change can flush the
//               pipe even while the video path is stalled.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_enable        - advance this stage
//               i_clear         - force valid to 0 (wins over i_enable)
//               i_valid/i_data  - value from the previous stage
//               o_valid/o_data  - registered stage contents
// Revision    : 1.0 - initial release
// ============================================================================
module delay_stage #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            // Data is not touched by a clear: flushed entries are don't-care
            // and leaving them alone keeps the data path free of clear logic.
            if (i_enable) begin
                r_data <= i_data;
            end
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_enable) begin
                r_valid <= i_valid;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pixel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : pixel_delay_line
// Description : Stallable pixel delay line. Delays a pixel stream and its
//               valid tag by a run-time selectable 0..MAX_DEPTH enabled
//               cycles. A delay load flushes all in-flight valids so no stale
//               pixels leak across a delay change.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               io_data_in       - pixel in
//               io_valid_in      - pixel in is valid
//               io_enable        - advance pipe (0 = stall, all state holds)
//               io_delay_load    - pulse: latch io_delay_sel, flush valids
//               io_delay_sel     - requested delay in enabled cycles
//               io_data_out      - delayed pixel
//               io_valid_out     - delayed pixel is valid
//               io_delay_cur     - delay currently in force
//               io_sel_err       - last load requested more than MAX_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_delay_line #(
    parameter int DATA_W        = pixel_pkg::PIXEL_W,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DELAY = pixel_pkg::DEFAULT_DELAY,
    parameter int SEL_W         = $clog2(MAX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] io_data_in,
    input  logic              io_valid_in,
    input  logic              io_enable,
    input  logic              io_delay_load,
    input  logic [SEL_W-1:0]  io_delay_sel,
    output logic [DATA_W-1:0] io_data_out,
    output logic              io_valid_out,
    output logic [SEL_W-1:0]  io_delay_cur,
    output logic              io_sel_err
);

    import pixel_pkg::*;

    localparam logic [SEL_W-1:0] c_MAX_SEL   = SEL_W'(MAX_DEPTH);
    localparam logic [SEL_W-1:0] c_RST_DELAY = SEL_W'(DEFAULT_DELAY);

    // ------------------------------------------------------------------------
    // Delay register and sticky range error
    // ------------------------------------------------------------------------
    logic [SEL_W-1:0] r_delay;
    logic             r_sel_err;

    // A load takes effect regardless of io_enable so retuning works during
    // blanking stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay   <= c_RST_DELAY;
            r_sel_err <= 1'b0;
        end else if (io_delay_load) begin
            if (io_delay_sel > c_MAX_SEL) begin
                r_delay   <= c_MAX_SEL;
                r_sel_err <= 1'b1;
            end else begin
                r_delay   <= io_delay_sel;
                r_sel_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage chain: index 0 is the pipe input, index i+1 is stage i's output
    // ------------------------------------------------------------------------
    logic              w_chain_valid [0:MAX_DEPTH];
    logic [DATA_W-1:0] w_chain_data  [0:MAX_DEPTH];
    logic              w_clear       [0:MAX_DEPTH-1];

    assign w_chain_valid[0] = io_valid_in;
    assign w_chain_data[0]  = io_data_in;

    generate
        for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // On a load with enable the first stage takes the current
                // input as the first pixel of the new stream, so it is only
                // cleared when the pipe is stalled.
                assign w_clear[gi] = io_delay_load & ~io_enable;
            end else begin : g_rest
                assign w_clear[gi] = io_delay_load;
            end

            delay_stage #(
                .DATA_W (DATA_W)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .i_enable (io_enable),
                .i_clear  (w_clear[gi]),
                .i_valid  (w_chain_valid[gi]),
                .i_data   (w_chain_data[gi]),
                .o_valid  (w_chain_valid[gi+1]),
                .o_data   (w_chain_data[gi+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Output tap: delay D >= 1 selects chain[D] (= stage D-1); D = 0 bypasses
    // ------------------------------------------------------------------------
    logic              w_tap_valid;
    logic [DATA_W-1:0] w_tap_data;

    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int i = 1; i <= MAX_DEPTH; i++) begin
            if (r_delay == SEL_W'(i)) begin
                w_tap_valid = w_chain_valid[i];
                w_tap_data  = w_chain_data[i];
            end
        end
    end

    assign io_valid_out = (r_delay == '0) ? io_valid_in : w_tap_valid;
    assign io_data_out  = (r_delay == '0) ? io_data_in  : w_tap_data;
    assign io_delay_cur = r_delay;
    assign io_sel_err   = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_delay_line
// Description : Self-checking bench for pixel_delay_line. Directed scenarios
//               followed by random traffic, all compared against a history
//               based reference model of the delay line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_delay_line;

    import pixel_pkg::*;

    localparam int DATA_W    = 24;
    localparam int MAX_DEPTH = 16;
    localparam int SEL_W     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] io_data_in;
    logic              io_valid_in;
    logic              io_enable;
    logic              io_delay_load;
    logic [SEL_W-1:0]  io_delay_sel;
    logic [DATA_W-1:0] io_data_out;
    logic              io_valid_out;
    logic [SEL_W-1:0]  io_delay_cur;
    logic              io_sel_err;

    always #5 clk = ~clk;

    pixel_delay_line #(
        .DATA_W        (DATA_W),
        .MAX_DEPTH     (MAX_DEPTH),
        .DEFAULT_DELAY (4),
        .SEL_W         (SEL_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .io_data_in    (io_data_in),
        .io_valid_in   (io_valid_in),
        .io_enable     (io_enable),
        .io_delay_load (io_delay_load),
        .io_delay_sel  (io_delay_sel),
        .io_data_out   (io_data_out),
        .io_valid_out  (io_valid_out),
        .io_delay_cur  (io_delay_cur),
        .io_sel_err    (io_sel_err)
    );

    // ------------------------------------------------------------------------
    // Reference model: every pixel accepted on an enabled edge since reset is
    // kept in order. With delay D the output is the D-th most recent accepted
    // pixel; it counts as valid only if it was accepted at or after the last
    // load. Before D pixels exist the reset contents (all zero) show through.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t hist[$];
    int   m_load_idx;
    int   m_delay;
    bit   m_err;
    bit   m_loaded;
    bit   m_known = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, then advance
    // the model by the edge that consumes those inputs.
    task automatic step(input bit rst, input bit en, input bit vin,
                        input logic [DATA_W-1:0] din, input bit ld, input int sel);
        int                k;
        logic              ev;
        logic [DATA_W-1:0] ed;
        bit                check_d;
        ent_t              e;
        @(negedge clk);
        reset         = rst;
        io_enable     = en;
        io_valid_in   = vin;
        io_data_in    = din;
        io_delay_load = ld;
        io_delay_sel  = SEL_W'(sel);
        #1;
        if (m_known) begin
            if (m_delay == 0) begin
                ev      = vin;
                ed      = din;
                check_d = 1'b1;
            end else begin
                k = hist.size() - m_delay;
                if (k < 0) begin
                    ev      = 1'b0;
                    ed      = '0;
                    check_d = !m_loaded;
                end else begin
                    ev      = (k >= m_load_idx) ? hist[k].v : 1'b0;
                    ed      = hist[k].d;
                    check_d = ev;
                end
            end
            chk("delay_cur", 32'(io_delay_cur), 32'(m_delay));
            chk("sel_err", 32'(io_sel_err), 32'(m_err));
            chk("valid_out", 32'(io_valid_out), 32'(ev));
            if (check_d) chk("data_out", 32'(io_data_out), 32'(ed));
        end
        @(posedge clk);
        if (rst) begin
            hist.delete();
            m_load_idx = 0;
            m_delay    = 4;
            m_err      = 1'b0;
            m_loaded   = 1'b0;
            m_known    = 1'b1;
        end else begin
            if (ld) begin
                if (sel > MAX_DEPTH) begin
                    m_delay = MAX_DEPTH;
                    m_err   = 1'b1;
                end else begin
                    m_delay = sel;
                    m_err   = 1'b0;
                end
                m_load_idx = hist.size();
                m_loaded   = 1'b1;
            end
            if (en) begin
                e.v = vin;
                e.d = din;
                hist.push_back(e);
            end
        end
    endtask

    initial begin
        pixel_t px;
        reset         = 1'b1;
        io_enable     = 1'b0;
        io_valid_in   = 1'b0;
        io_data_in    = '0;
        io_delay_load = 1'b0;
        io_delay_sel  = '0;

        // 1: reset, then a ramp with default delay 4
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) step(0, 1, 1, DATA_W'(i), 0, 0);

        // 2: zero delay bypass
        step(0, 1, 0, 0, 1, 0);
        px.r = 8'hAB; px.g = 8'hCD; px.b = 8'hEF;
        step(0, 1, 1, px, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, DATA_W'($urandom), 0, 0);

        // 3: D=3, stall mid-stream
        step(0, 1, 1, 24'h100, 1, 3);
        for (int i = 1; i <= 6; i++) step(0, 1, 1, DATA_W'(24'h100 + i), 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, DATA_W'(24'hBAD000 + i), 0, 0);
        for (int i = 7; i <= 12; i++) step(0, 1, 1, DATA_W'(24'h100 + i), 0, 0);

        // 4: D=8 full pipe, then retune to 2
        step(0, 1, 1, 24'h200, 1, 8);
        for (int i = 1; i <= 12; i++) step(0, 1, 1, DATA_W'(24'h200 + i), 0, 0);
        step(0, 1, 1, 24'h2FF, 1, 2);
        for (int i = 0; i < 4; i++) step(0, 1, 1, DATA_W'(24'h300 + i), 0, 0);

        // 5: out-of-range load clamps and flags, next legal load clears
        step(0, 1, 1, 24'h400, 1, 20);
        for (int i = 1; i <= 4; i++) step(0, 1, 1, DATA_W'(24'h400 + i), 0, 0);
        step(0, 1, 1, 24'h500, 1, 5);
        step(0, 0, 0, 0, 0, 0);

        // 6: bubble pattern with D=5, then reset mid-stream
        for (int i = 0; i < 14; i++) step(0, 1, i[0], DATA_W'(24'h600 + i), 0, 0);
        step(1, 1, 1, 24'h6FF, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, DATA_W'(24'h700 + i), 0, 0);

        // Random traffic, including loads during stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 DATA_W'($urandom),
                 ($urandom_range(0, 39) == 0),
                 int'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
